mix_boot_loader: RTL

//  Upstream feeder for the MIX core: receives a byte stream from a host link and writes MIX words into core memory.
//  It holds the core in reset (cpu_reset) until a complete, checksum-valid image has been written.
//  It sits between the host byte receiver and the core memory write port. The core starts at pc=0 once cpu_reset drops.

---
 rtl/mix_boot_loader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mix_boot_loader.sv
// mix_boot_loader: parses framed host byte stream into MIX core memory writes.
// Frame: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT x 4 data bytes, CHK (XOR of data).
// Holds the core in reset until a complete, checksum-valid image has landed.
module mix_boot_loader #(
  parameter int         ADDR_W    = 12,
  parameter int         WORD_W    = 31,
  parameter logic [7:0] SYNC_BYTE = 8'h4D,
  parameter int         TIMEOUT   = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic [1:0]        err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_HDR  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TO   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CHK} state_t;

  state_t              r_state, w_state;
  logic [1:0]          r_hdr_idx, w_hdr_idx;
  logic [7:0]          r_addr_hi, w_addr_hi;
  logic [7:0]          r_addr_lo, w_addr_lo;
  logic [7:0]          r_cnt_hi, w_cnt_hi;
  logic [ADDR_W-1:0]   r_ptr, w_ptr;
  logic [CNT_W-1:0]    r_words, w_words;
  logic [1:0]          r_lane, w_lane;
  logic [WORD_W-9:0]   r_word, w_word;      // first three bytes of the word in flight
  logic [7:0]          r_xor, w_xor;
  logic [TO_W-1:0]     r_idle, w_idle;
  logic                r_in_ready, w_in_ready;
  logic                r_mem_we, w_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata, w_mem_wdata;
  logic                r_cpu_reset, w_cpu_reset;
  logic                r_done, w_done;
  logic [1:0]          r_err, w_err;

  logic                w_accept;
  logic [15:0]         w_hdr_addr;
  logic [15:0]         w_hdr_cnt;
  logic                w_hdr_bad;
  logic [WORD_W-1:0]   w_full;

  assign w_accept   = in_valid & r_in_ready;
  assign w_hdr_addr = {r_addr_hi, r_addr_lo};
  assign w_hdr_cnt  = {r_cnt_hi, in_data};
  assign w_hdr_bad  = ({1'b0, w_hdr_addr} >= 17'(DEPTH)) ||
                      (w_hdr_cnt == 16'd0) ||
                      ({1'b0, w_hdr_cnt} > 17'(DEPTH));
  // bit31 of the big-endian 32-bit value falls off the top of r_word
  assign w_full     = {r_word, in_data};

  // Frame parser: next state and next values of every register
  always_comb begin
    w_state     = r_state;
    w_hdr_idx   = r_hdr_idx;
    w_addr_hi   = r_addr_hi;
    w_addr_lo   = r_addr_lo;
    w_cnt_hi    = r_cnt_hi;
    w_ptr       = r_ptr;
    w_words     = r_words;
    w_lane      = r_lane;
    w_word      = r_word;
    w_xor       = r_xor;
    w_idle      = r_idle;
    w_in_ready  = 1'b1;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_cpu_reset = r_cpu_reset;
    w_done      = 1'b0;
    w_err       = r_err;

    if (r_state == S_IDLE) begin
      if (w_accept && (in_data == SYNC_BYTE)) begin
        w_cpu_reset = 1'b1;
        w_err       = ERR_NONE;
        w_xor       = 8'h00;
        w_hdr_idx   = 2'd0;
        w_idle      = '0;
        w_state     = S_HDR;
      end else begin
        w_idle = '0;
      end
    end else if (!w_accept) begin
      // inside a frame with no byte this cycle: run the idle timer
      if (r_idle == TO_LAST) begin
        w_err   = ERR_TO;
        w_idle  = '0;
        w_state = S_IDLE;
      end else begin
        w_idle = r_idle + TO_W'(1);
      end
    end else begin
      w_idle = '0;
      case (r_state)
        S_HDR: begin
          w_hdr_idx = r_hdr_idx + 2'd1;
          case (r_hdr_idx)
            2'd0: w_addr_hi = in_data;
            2'd1: w_addr_lo = in_data;
            2'd2: w_cnt_hi  = in_data;
            2'd3: begin
              if (w_hdr_bad) begin
                w_err   = ERR_HDR;
                w_state = S_IDLE;
              end else begin
                w_ptr   = w_hdr_addr[ADDR_W-1:0];
                w_words = w_hdr_cnt[CNT_W-1:0];
                w_lane  = 2'd0;
                w_state = S_DATA;
              end
            end
            default: w_hdr_idx = 2'd0;
          endcase
        end
        S_DATA: begin
          w_xor = r_xor ^ in_data;
          if (r_lane == 2'd3) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_ptr;
            w_mem_wdata = w_full;
            w_ptr       = r_ptr + ADDR_W'(1);
            w_words     = r_words - CNT_W'(1);
            w_lane      = 2'd0;
            if (r_words == CNT_W'(1)) begin
              w_state = S_CHK;
            end else begin
              w_state = S_DATA;
            end
          end else begin
            w_word = {r_word[WORD_W-17:0], in_data};
            w_lane = r_lane + 2'd1;
          end
        end
        S_CHK: begin
          if (in_data == r_xor) begin
            w_done      = 1'b1;
            w_cpu_reset = 1'b0;
          end else begin
            w_err = ERR_CHK;
          end
          w_state = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hdr_idx   <= 2'd0;
      r_addr_hi   <= 8'h00;
      r_addr_lo   <= 8'h00;
      r_cnt_hi    <= 8'h00;
      r_ptr       <= '0;
      r_words     <= '0;
      r_lane      <= 2'd0;
      r_word      <= '0;
      r_xor       <= 8'h00;
      r_idle      <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= ERR_NONE;
    end else begin
      r_state     <= w_state;
      r_hdr_idx   <= w_hdr_idx;
      r_addr_hi   <= w_addr_hi;
      r_addr_lo   <= w_addr_lo;
      r_cnt_hi    <= w_cnt_hi;
      r_ptr       <= w_ptr;
      r_words     <= w_words;
      r_lane      <= w_lane;
      r_word      <= w_word;
      r_xor       <= w_xor;
      r_idle      <= w_idle;
      r_in_ready  <= w_in_ready;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_cpu_reset <= w_cpu_reset;
      r_done      <= w_done;
      r_err       <= w_err;
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_reset = r_cpu_reset;
  assign done      = r_done;
  assign err       = r_err;

endmodule
